// File: rtl/xps2_rx.sv
// PS/2 receive front end with scan-code prefix decoding and an event FIFO.
// Ports:
//   clk, rst      system clock and synchronous active-low reset
//   ps2_clk/data  asynchronous PS/2 lines (synchronized and glitch-filtered here)
//   ev_data       FIFO head event {ext, brk, code[7:0]}, valid while ev_valid
//   ev_valid      FIFO non-empty
//   ev_ready      consumer pop strobe (pop when ev_valid & ev_ready)
//   ovf           sticky overflow flag (event dropped on a full FIFO)
//   err_cnt       saturating count of bad or timed-out frames
//   clr           clears ovf and err_cnt
module xps2_rx #(
  parameter int unsigned FIFO_AW  = 3,
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned TIMEOUT  = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] ev_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ovf,
  output logic [7:0] err_cnt,
  input  logic       clr
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned FCW   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned TCW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;

  // ---------------------------------------------------------------
  // Line conditioning: index 0 = ps2_clk, index 1 = ps2_data
  // ---------------------------------------------------------------
  logic [1:0]     sync1, sync2, filt;
  logic [FCW-1:0] fcnt [2];
  logic           clk_prev;

  // 2-flop synchronizer followed by a level-hold filter
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1    <= 2'b11;
      sync2    <= 2'b11;
      filt     <= 2'b11;
      clk_prev <= 1'b1;
      fcnt[0]  <= '0;
      fcnt[1]  <= '0;
    end else begin
      sync1    <= {ps2_data, ps2_clk};
      sync2    <= sync1;
      clk_prev <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCW'(FILT_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FCW'(1);
        end
      end
    end
  end

  logic sample, sbit;
  assign sample = clk_prev & ~filt[0];
  assign sbit   = filt[1];

  // ---------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------
  state_t         state_q, state_d;
  logic [3:0]     bit_cnt;
  logic [TCW-1:0] tcnt;
  logic [9:0]     shreg;       // {stop, parity, data[7:0]} after 10 samples
  logic           ext_pend, brk_pend;
  logic           start, shift_en, timeout, accept, reject, push;
  logic [9:0]     push_data;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    shift_en = 1'b0;
    timeout  = 1'b0;
    accept   = 1'b0;
    reject   = 1'b0;
    push     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sample && !sbit) begin
          start   = 1'b1;
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (sample) begin
          shift_en = 1'b1;
          if (bit_cnt == 4'd9) state_d = S_CHECK;
        end else if (tcnt == TCW'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        // odd parity over data+parity, and a high stop bit
        if ((^shreg[8:0]) && shreg[9]) begin
          accept = 1'b1;
          push   = (shreg[7:0] != 8'hE0) && (shreg[7:0] != 8'hF0);
        end else begin
          reject = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign push_data = {ext_pend, brk_pend, shreg[7:0]};

  // ---------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------
  logic [9:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0]      count, count_next;
  logic               full, do_push, do_pop;
  logic [9:0]         head_d;

  // Next-pointer/occupancy and the head word visible after this edge
  always_comb begin
    full       = (count == CW'(DEPTH));
    do_pop     = ev_valid & ev_ready;
    do_push    = push & (~full | do_pop);
    rd_next    = do_pop ? rd_ptr + FIFO_AW'(1) : rd_ptr;
    count_next = count + CW'(do_push) - CW'(do_pop);
    // a word written this cycle into the next head slot bypasses the array
    head_d     = (do_push && (wr_ptr == rd_next)) ? push_data : mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Datapath: frame shifting, counters, prefix flags, status and FIFO state
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt  <= '0;
      tcnt     <= '0;
      shreg    <= '0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      err_cnt  <= '0;
      ovf      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ev_valid <= 1'b0;
      ev_data  <= '0;
    end else begin
      if (start) begin
        bit_cnt <= '0;
        tcnt    <= '0;
      end else if (shift_en) begin
        shreg   <= {sbit, shreg[9:1]};
        bit_cnt <= bit_cnt + 4'd1;
        tcnt    <= '0;
      end else if (state_q == S_RECV) begin
        tcnt    <= tcnt + TCW'(1);
      end

      if (accept) begin
        if (shreg[7:0] == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (shreg[7:0] == 8'hF0) begin
          brk_pend <= 1'b1;
        end else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end else if (reject) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end

      if (clr)                                      err_cnt <= '0;
      else if ((reject || timeout) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

      if (clr)                          ovf <= 1'b0;
      else if (push && full && !do_pop) ovf <= 1'b1;

      if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      rd_ptr   <= rd_next;
      count    <= count_next;
      ev_valid <= (count_next != '0);
      ev_data  <= (count_next != '0) ? head_d : 10'd0;
    end
  end

endmodule

// File: tb/tb_xps2_rx.sv
// Self-checking bench for xps2_rx: directed scenarios plus randomized frames
// scored against a frame-level reference model and an expected-event queue.
module tb_xps2_rx;

  localparam int unsigned AW    = 3;
  localparam int unsigned FL    = 4;
  localparam int unsigned TO    = 100;
  localparam int unsigned DEPTH = 1 << AW;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ev_ready = 1'b0;
  logic       clr = 1'b0;
  logic [9:0] ev_data;
  logic       ev_valid;
  logic       ovf;
  logic [7:0] err_cnt;

  xps2_rx #(.FIFO_AW(AW), .FILT_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ovf(ovf), .err_cnt(err_cnt), .clr(clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  logic [9:0] exp_q[$];
  bit         ext_m = 0, brk_m = 0, ovf_m = 0;
  int         err_m = 0;

  int         rdy_mode = 0;   // 0 hold low, 1 hold high, 2 random
  int         fall_cyc = 0;
  int         rise_cyc = 0;
  logic       prev_valid = 1'b0;
  logic [9:0] mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // consumer side: every handshake must match the next expected event
  always @(negedge clk) begin
    if (rst && ev_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = ev_valid;
    if (rst && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        check("ev_spurious", 32'(ev_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ev_data", 32'(ev_data), 32'(mon_e));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       ev_ready = 1'b0;
      1:       ev_ready = 1'b1;
      default: ev_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one PS/2 bit: data settles while clock is high, then a 10-cycle low pulse
  task automatic send_bit(input bit b);
    ps2_data = b;
    tick(5);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    tick(10);
    ps2_clk  = 1'b1;
    tick(5);
  endtask

  task automatic send_frame(input logic [7:0] code, input bit par_bad, input bit stop_bad);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit((~^code) ^ par_bad);
    send_bit(~stop_bad);
    ps2_data = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] code, input bit good);
    if (!good) begin
      if (err_m < 255) err_m++;
      ext_m = 0;
      brk_m = 0;
    end else if (code == 8'hE0) begin
      ext_m = 1;
    end else if (code == 8'hF0) begin
      brk_m = 1;
    end else begin
      if (exp_q.size() < DEPTH) exp_q.push_back({ext_m, brk_m, code});
      else                      ovf_m = 1;
      ext_m = 0;
      brk_m = 0;
    end
  endtask

  task automatic good_frame(input logic [7:0] code);
    model_frame(code, 1'b1);
    send_frame(code, 1'b0, 1'b0);
    tick(4);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    check(tag, 32'(exp_q.size()), 32'd0);
    tick(3);
    check({tag, "_empty"}, 32'(ev_valid), 32'd0);
  endtask

  logic [7:0] code;
  bit         good, pbad;
  int         r;

  initial begin
    // reset values
    tick(5);
    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_data",  32'(ev_data),  32'd0);
    check("rst_ovf",   32'(ovf),      32'd0);
    check("rst_err",   32'(err_cnt),  32'd0);
    rst = 1'b1;
    rdy_mode = 1;
    tick(5);

    // make / break / make with latency from stop-bit clock fall to ev_valid
    begin
      logic [7:0] seq [3] = '{8'h69, 8'hF0, 8'h69};
      for (int i = 0; i < 3; i++) begin
        rise_cyc = 0;
        good_frame(seq[i]);
        if (seq[i] != 8'hF0)
          check("latency", 32'(rise_cyc - fall_cyc), 32'(2 + FL + 2));
      end
    end
    drain("drain_69");
    check("err_69", 32'(err_cnt), 32'd0);

    // extended break sequence collapses into one event
    good_frame(8'hE0);
    good_frame(8'hF0);
    good_frame(8'h5A);
    drain("drain_35a");

    // bad parity rejected, then a plain good frame
    model_frame(8'h79, 1'b0);
    send_frame(8'h79, 1'b1, 1'b0);
    tick(4);
    check("par_err", 32'(err_cnt), 32'(err_m));
    check("par_noev", 32'(ev_valid), 32'd0);
    good_frame(8'h7C);
    drain("drain_7c");

    // stalled clock after 5 bits times out
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ps2_data = 1'b1;
    tick(TO + 50);
    err_m++;
    check("timeout_err", 32'(err_cnt), 32'(err_m));
    check("timeout_noev", 32'(ev_valid), 32'd0);
    good_frame(8'h1C);
    drain("drain_1c");

    // overflow: nine make codes with no consumer
    rdy_mode = 0;
    tick(2);
    for (int i = 0; i < 9; i++) begin
      good_frame(8'h10 + 8'(i));
      check("ovf_step", 32'(ovf), 32'(ovf_m));
    end
    check("ovf_full_valid", 32'(ev_valid), 32'd1);
    rdy_mode = 1;
    drain("drain_ovf");
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    ovf_m = 0;
    err_m = 0;
    check("clr_ovf", 32'(ovf), 32'd0);
    check("clr_err", 32'(err_cnt), 32'd0);

    // error counter saturation
    for (int i = 0; i < 255; i++) begin
      model_frame(8'(i), 1'b0);
      send_frame(8'(i), i[0], ~i[0]);
    end
    tick(4);
    check("err_sat", 32'(err_cnt), 32'd255);
    model_frame(8'h33, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0);
    tick(4);
    check("err_hold", 32'(err_cnt), 32'd255);

    // reset in the middle of a frame with an event pending
    rdy_mode = 0;
    good_frame(8'h2B);
    check("pre_rst_valid", 32'(ev_valid), 32'd1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst = 1'b0;
    ps2_data = 1'b1;
    ps2_clk  = 1'b1;
    tick(3);
    exp_q.delete();
    ext_m = 0; brk_m = 0; ovf_m = 0; err_m = 0;
    rst = 1'b1;
    tick(3);
    check("mid_rst_valid", 32'(ev_valid), 32'd0);
    check("mid_rst_data",  32'(ev_data),  32'd0);
    check("mid_rst_err",   32'(err_cnt),  32'd0);
    check("mid_rst_ovf",   32'(ovf),      32'd0);
    rdy_mode = 1;
    good_frame(8'h74);
    drain("drain_74");

    // randomized frames with random consumer back-pressure
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      r    = int'($urandom_range(0, 9));
      code = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
      good = ($urandom_range(0, 5) != 0);
      pbad = 1'($urandom_range(0, 1));
      model_frame(code, good);
      send_frame(code, !good && pbad, !good && !pbad);
      tick(4);
      check("rnd_err", 32'(err_cnt), 32'(err_m));
      check("rnd_ovf", 32'(ovf), 32'(ovf_m));
    end
    rdy_mode = 1;
    drain("drain_rnd");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/xps2_rx.md
XPS2_RX -- requirements
Module: xps2_rx

Interface
REQ-001 Parameter FIFO_AW, default 3, FIFO address width (depth = 2**FIFO_AW entries).
REQ-002 Parameter FILT_LEN, default 4, clk cycles a synchronized PS/2 line must hold a new level before the filtered level changes.
REQ-003 Parameter TIMEOUT, default 5000, max clk cycles between consecutive frame bits before the frame is abandoned.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low (0 = reset).
REQ-006 ps2_clk  input  1  asynchronous PS/2 clock line.
REQ-007 ps2_data  input  1  asynchronous PS/2 data line.
REQ-008 ev_data  output  10  FIFO head event {ext, brk, code[7:0]}.
REQ-009 ev_valid  output  1  FIFO non-empty.
REQ-010 ev_ready  input  1  consumer pop; pop occurs when ev_valid & ev_ready.
REQ-011 ovf  output  1  sticky overflow flag.
REQ-012 err_cnt  output  8  saturating count of bad frames.
REQ-013 clr  input  1  clears ovf and err_cnt.

Function
REQ-014 ps2_clk and ps2_data SHALL each pass a 2-flop synchronizer, then a FILT_LEN-cycle stability filter.
REQ-015 Bit sampling SHALL occur on the clk cycle a 1->0 transition of filtered ps2_clk is detected; filtered ps2_data is sampled.
REQ-016 Frame = 11 bits: start(0), 8 data LSB first, odd parity, stop(1).
REQ-017 FSM states: IDLE, RECV, CHECK.
REQ-018 IDLE -> RECV on a sample of 0; a sample of 1 in IDLE SHALL be ignored.
REQ-019 RECV SHALL count 10 further samples, then go to CHECK.
REQ-020 In RECV, a cycle counter SHALL reset on each sample; on reaching TIMEOUT the FSM SHALL return to IDLE, discard the partial frame, and increment err_cnt.
REQ-021 CHECK lasts one cycle, then -> IDLE.
REQ-022 CHECK SHALL accept the frame only if data^parity has odd weight and stop = 1.
REQ-023 A rejected frame SHALL increment err_cnt, saturating at 255, and clear both prefix flags.
REQ-024 An accepted 0xE0 SHALL set ext_pend and push nothing.
REQ-025 An accepted 0xF0 SHALL set brk_pend and push nothing.
REQ-026 Any other accepted code SHALL push {ext_pend, brk_pend, code} and clear both flags.
REQ-027 Push occurs in the CHECK cycle; ev_valid SHALL rise on the following cycle, so latency from the stop-bit sample to ev_valid is 2 clk.
REQ-028 FIFO SHALL be first-word-fall-through, depth 2**FIFO_AW, with ev_data valid whenever ev_valid = 1.
REQ-029 Push while full and no pop: event dropped, ovf set, FIFO contents unchanged.
REQ-030 Push and pop in the same cycle while full: both performed, ovf unchanged.
REQ-031 Pop while empty SHALL be ignored.
REQ-032 Push while empty SHALL make the event visible on the next cycle.
REQ-033 clr SHALL zero ovf and err_cnt on the next cycle.
REQ-034 If a set/increment event coincides with clr, clr SHALL win.
REQ-035 err_cnt SHALL hold at 255 once saturated.

Reset
REQ-036 While rst = 0 at a clk edge: FSM = IDLE, bit and timeout counters = 0, prefix flags = 0, FIFO emptied, ev_valid = 0, ev_data = 0, ovf = 0, err_cnt = 0.
REQ-037 Synchronizer and filter state SHALL reset to 1 (idle line level).
REQ-038 Reset mid-frame SHALL discard the partial frame; the next start bit after reset release SHALL be received normally.

Verification
REQ-039 Frames 0x69, 0xF0, 0x69 at 2500-clk bit period -> events 0x069 then 0x169; ev_valid 2 clk after each stop-bit sample; err_cnt = 0.
REQ-040 Frames 0xE0, 0xF0, 0x5A -> single event 0x35A.
REQ-041 Frame 0x79 with even parity -> no event, err_cnt = 1; a following good 0x7C -> event 0x07C with ext = brk = 0.
REQ-042 ev_ready = 0, 9 make codes sent with FIFO_AW = 3 -> 8 events held in order; ovf = 1 after the 9th; clr -> ovf = 0.
REQ-043 ps2_clk stopped after 5 bits for more than TIMEOUT cycles -> err_cnt = 1, FSM = IDLE; next full frame received correctly.
REQ-044 rst = 0 asserted mid-frame, then released -> all outputs at reset values; a subsequent 0x74 frame -> event 0x074.
